// File: rtl/rr_mux_arbiter_nbit.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter_nbit
//
// Merges CH producer channels, each N bits wide, onto a single registered
// valid/ready output stream. The winning channel is chosen each cycle by
// round-robin (mode=0) or fixed lowest-index priority (mode=1). The output
// register can be refilled in the same cycle it is drained, so a continuously
// ready sink sees one word per clock.
//
// Parameters:
//   N    - data width per channel (>= 1)
//   CH   - number of input channels (>= 2, any value)
//   SELW - width of the channel index, $clog2(CH)
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   in_data      flattened channel data, channel i at [i*N +: N]
//   in_valid     per-channel data valid
//   in_ready     per-channel accept, one-hot or zero
//   mode         0 = round-robin, 1 = fixed priority
//   out_data     registered selected word
//   out_ch       index of the channel that produced out_data
//   out_valid    output register holds a word
//   out_ready    downstream accept
//   grant_count  (ARB_GRANT_COUNT_EN only) 16-bit wrapping count of transfers
//   clr_count    (ARB_GRANT_COUNT_EN only) synchronous clear of grant_count
//
// Optional feature macro: ARB_GRANT_COUNT_EN
// ---------------------------------------------------------------------------
module rr_mux_arbiter_nbit #(
    parameter int N    = 8,
    parameter int CH   = 8,
    localparam int SELW = $clog2(CH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [CH*N-1:0]   in_data,
    input  logic [CH-1:0]     in_valid,
    output logic [CH-1:0]     in_ready,
    input  logic              mode,
    output logic [N-1:0]      out_data,
    output logic [SELW-1:0]   out_ch,
    output logic              out_valid,
`ifdef ARB_GRANT_COUNT_EN
    input  logic              clr_count,
    output logic [15:0]       grant_count,
`endif
    input  logic              out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [N-1:0]      data_q, data_d;
    logic [SELW-1:0]   ch_q, ch_d;
    logic [SELW-1:0]   ptr_q, ptr_d;

    logic [N-1:0]      ch_data [CH];
    logic              load_en;
    logic              grant_found;
    logic [SELW-1:0]   grant_idx;
    logic              transfer;

    // Unpack the flattened input bus so the winner can be selected by index.
    for (genvar gi = 0; gi < CH; gi++) begin : g_unpack
        assign ch_data[gi] = in_data[gi*N +: N];
    end

    assign load_en = (state_q == EMPTY) || out_ready;

    // Arbitration: walk CH candidates starting at ptr (round-robin, wrapping
    // at CH-1) or at 0 (fixed priority); the first requester wins. The wrap
    // is done arithmetically so a non-power-of-two CH never yields an index
    // outside the channel range.
    always_comb begin : arbitrate
        int cand;
        cand        = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < CH; k++) begin
            if (mode) begin
                cand = k;
            end else begin
                cand = int'(ptr_q) + k;
                if (cand >= CH) begin
                    cand = cand - CH;
                end
            end
            if (!grant_found && in_valid[cand[SELW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[SELW-1:0];
            end
        end
    end

    // reset_n is folded in so no producer sees an accept while the output
    // register is being held in reset.
    assign transfer = load_en && grant_found && reset_n;

    always_comb begin
        in_ready = '0;
        if (transfer) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // Output register next state: load the winner, drain to EMPTY when the
    // sink takes the word and nobody is requesting, otherwise hold.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ch_d    = ch_q;
        ptr_d   = ptr_q;
        if (transfer) begin
            state_d = FULL;
            data_d  = ch_data[grant_idx];
            ch_d    = grant_idx;
            ptr_d   = (grant_idx == SELW'(CH - 1)) ? '0 : grant_idx + 1'b1;
        end else if (load_en) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            ch_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_ch    = ch_q;

`ifdef ARB_GRANT_COUNT_EN
    logic [15:0] count_q, count_d;

    // Clear takes precedence over an increment in the same cycle.
    always_comb begin
        count_d = count_q;
        if (clr_count) begin
            count_d = '0;
        end else if (transfer) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign grant_count = count_q;
`endif

endmodule

// File: tb/tb_rr_mux_arbiter_nbit.sv
// ---------------------------------------------------------------------------
// tb_rr_mux_arbiter_nbit
//
// Directed-vector bench for rr_mux_arbiter_nbit (N=8, CH=8). Each vector
// drives one cycle of mode/in_valid/out_ready with a hand-computed expected
// in_ready; granted words are pushed to a scoreboard queue and a separate
// monitor pops and compares them whenever the DUT hands a word downstream.
// Builds with or without ARB_GRANT_COUNT_EN.
// ---------------------------------------------------------------------------
module tb_rr_mux_arbiter_nbit;

    localparam int N    = 8;
    localparam int CH   = 8;
    localparam int SELW = 3;

    logic              clk;
    logic              reset_n;
    logic [CH*N-1:0]   in_data;
    logic [CH-1:0]     in_valid;
    logic [CH-1:0]     in_ready;
    logic              mode;
    logic [N-1:0]      out_data;
    logic [SELW-1:0]   out_ch;
    logic              out_valid;
    logic              out_ready;
`ifdef ARB_GRANT_COUNT_EN
    logic              clr_count;
    logic [15:0]       grant_count;
`endif

    rr_mux_arbiter_nbit #(.N(N), .CH(CH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .mode        (mode),
        .out_data    (out_data),
        .out_ch      (out_ch),
        .out_valid   (out_valid),
`ifdef ARB_GRANT_COUNT_EN
        .clr_count   (clr_count),
        .grant_count (grant_count),
`endif
        .out_ready   (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       mode;
        logic [7:0] valid;
        logic       ordy;
        logic [7:0] exp_rdy;
        logic [7:0] base;
        logic       chk_hold;
    } vec_t;

    vec_t                   vecs[$];
    logic [SELW+N-1:0]      exp_q[$];
    int                     n_vectors;
    int                     n_miscompares;
    logic                   exp_out_valid;
    logic                   mon_en;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic setPattern(input logic [7:0] base);
        for (int i = 0; i < CH; i++) begin
            in_data[i*N +: N] = base + 8'(i);
        end
    endtask

    task automatic addVec(input logic m, input logic [7:0] v, input logic r,
                          input logic [7:0] e, input logic [7:0] b, input logic h);
        vec_t t;
        t.mode = m; t.valid = v; t.ordy = r; t.exp_rdy = e; t.base = b; t.chk_hold = h;
        vecs.push_back(t);
    endtask

    // One vector per clock: drive after the edge, then check the registered
    // state left by the previous edge and the combinational in_ready.
    task automatic applyStimulus(input vec_t v);
        int g;
        @(posedge clk);
        #1;
        mode      = v.mode;
        in_valid  = v.valid;
        out_ready = v.ordy;
        setPattern(v.base);
        #1;
        checkOutput("out_valid", 32'(out_valid), 32'(exp_out_valid));
        checkOutput("in_ready", 32'(in_ready), 32'(v.exp_rdy));
        if (v.chk_hold) begin
            checkOutput("held_data", 32'(out_data), 32'h0000_00A5);
            checkOutput("held_ch", 32'(out_ch), 32'd6);
        end
        if (v.exp_rdy != 8'h00) begin
            g = 0;
            for (int i = 0; i < CH; i++) begin
                if (v.exp_rdy[i]) g = i;
            end
            exp_q.push_back({SELW'(g), v.base + 8'(g)});
            exp_out_valid = 1'b1;
        end else if (v.ordy) begin
            exp_out_valid = 1'b0;
        end
    endtask

    // Monitor: a word leaves the DUT when out_valid && out_ready at the edge.
    always @(negedge clk) begin
        if (mon_en && reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_word", 32'({out_ch, out_data}), 32'hFFFF_FFFF);
            end else begin
                checkOutput("scoreboard", 32'({out_ch, out_data}), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;
        exp_out_valid = 1'b0;
        mon_en        = 1'b1;
        reset_n       = 1'b0;
        mode          = 1'b0;
        in_valid      = 8'hFF;
        out_ready     = 1'b1;
        setPattern(8'h10);
`ifdef ARB_GRANT_COUNT_EN
        clr_count     = 1'b0;
`endif

        // Reset held with every channel requesting.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_out_ch", 32'(out_ch), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        in_valid = 8'h00;
        reset_n  = 1'b1;

        // Round-robin fairness: 0..7 then 0 again.
        addVec(0, 8'hFF, 1, 8'h01, 8'h10, 0);
        addVec(0, 8'hFF, 1, 8'h02, 8'h10, 0);
        addVec(0, 8'hFF, 1, 8'h04, 8'h10, 0);
        addVec(0, 8'hFF, 1, 8'h08, 8'h10, 0);
        addVec(0, 8'hFF, 1, 8'h10, 8'h10, 0);
        addVec(0, 8'hFF, 1, 8'h20, 8'h10, 0);
        addVec(0, 8'hFF, 1, 8'h40, 8'h10, 0);
        addVec(0, 8'hFF, 1, 8'h80, 8'h10, 0);
        addVec(0, 8'hFF, 1, 8'h01, 8'h10, 0);
        // Sparse and wrap: ch5 leaves ptr=6, then 0,1; ptr=2 -> 7, then 0.
        addVec(0, 8'h20, 1, 8'h20, 8'h10, 0);
        addVec(0, 8'h03, 1, 8'h01, 8'h10, 0);
        addVec(0, 8'h03, 1, 8'h02, 8'h10, 0);
        addVec(0, 8'h81, 1, 8'h80, 8'h10, 0);
        addVec(0, 8'h81, 1, 8'h01, 8'h10, 0);
        // Fixed priority: ch2 every cycle, then ch5 once ch2 drops.
        addVec(1, 8'hA4, 1, 8'h04, 8'h10, 0);
        addVec(1, 8'hA4, 1, 8'h04, 8'h10, 0);
        addVec(1, 8'hA4, 1, 8'h04, 8'h10, 0);
        addVec(1, 8'hA0, 1, 8'h20, 8'h10, 0);
        addVec(1, 8'hA0, 1, 8'h20, 8'h10, 0);
        addVec(0, 8'h00, 1, 8'h00, 8'h10, 0);
        // Backpressure: ch6 loads A5 (ptr was 6), held 5 clks, then no bubble.
        addVec(0, 8'h40, 0, 8'h40, 8'h9F, 0);
        for (int i = 0; i < 5; i++) addVec(0, 8'hFF, 0, 8'h00, 8'h9F, 1);
        addVec(0, 8'hFF, 1, 8'h80, 8'h9F, 1);
        addVec(0, 8'hFF, 1, 8'h01, 8'h9F, 0);
        addVec(0, 8'h00, 1, 8'h00, 8'h9F, 0);
        addVec(0, 8'h00, 1, 8'h00, 8'h9F, 0);

        foreach (vecs[i]) applyStimulus(vecs[i]);
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

        // Reset mid-transfer: word discarded at once, ptr back to 0.
        @(posedge clk);
        #1;
        setPattern(8'h10);
        in_valid  = 8'h01;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 8'h00;
        checkOutput("mid_loaded", 32'(out_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        in_valid  = 8'hFF;
        #1;
        checkOutput("ptr_after_rst", 32'(in_ready), 32'h01);
        in_valid = 8'h00;

`ifdef ARB_GRANT_COUNT_EN
        // Clear wins over a simultaneous transfer; then 70000 transfers wrap.
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        clr_count = 1'b1;
        in_valid  = 8'h01;
        @(posedge clk);
        #1;
        checkOutput("clr_wins", 32'(grant_count), 32'd0);
        clr_count = 1'b0;
        in_valid  = 8'hFF;
        repeat (70000) @(posedge clk);
        #1;
        in_valid = 8'h00;
        checkOutput("grant_count_wrap", 32'(grant_count), 32'd4464);
        @(posedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
